poly_string_synth: RTL
======================

// Module: poly_string_synth
// PURPOSE
//  Parametrised multi-string tone generator for the FPGA guitar. Converts a shared one-hot fret bus
//  and per-string pluck inputs into square-wave notes with a per-string decay envelope. Mixes all
//  strings into a registered multi-bit sample and a 1-bit sigma-delta speaker output.
// PARAMETERS
//  NUM_STRINGS  4                        number of strings / voices (1..8)
//  NUM_FRETS    16                       width of fret bus
//  CNT_W        20                       half-period counter width
//  AMP_W        8                        envelope amplitude width
//  DECAY_DIV    390625                   clk cycles per 1-LSB amplitude decrement (>=1)
//  NOTE_BASE    {6'd15,6'd10,6'd5,6'd0}  packed 6b open-string note index per string, string 0 in LSBs (E2=0)
// PORTS
//  clk      in   1                       system clock, 100 MHz
//  reset    in   1                       asynchronous, active-low; clears all state
//  frets    in   NUM_FRETS               one-hot fret select shared by all strings; 0 = open
//  pluck    in   NUM_STRINGS             level per string; rising edge starts note, low mutes
//  active   out  NUM_STRINGS             string sounding (pluck high and amplitude != 0)
//  mix      out  AMP_W+$clog2(NUM_STRINGS)  registered sum of string samples (MIX_W)
//  speaker  out  1                       sigma-delta bitstream of mix
// BEHAVIOUR
//  Reset (async assert): all counters, squares, amplitudes, period regs, mix, accumulator, active,
//   speaker = 0. Release is synchronous to clk.
//  Fret decode: fret = 1 + index of lowest set bit of frets; frets==0 -> fret 0. Multi-hot: lowest bit wins.
//  Note: n = NOTE_BASE[s] + fret (7b). octave = n/12, semi = n%12; HP = TABLE[semi] >> octave.
//  TABLE (E2..D#3): 606722,572672,540541,510204,481556,454545,429037,404957,382234,360776,340530,321419.
//  Per-string period reg P latches HP on a pluck rising edge and at every square toggle.
//   Fret changes mid-note therefore take effect glitch-free at the next toggle.
//  Tone: while pluck[s] high, cnt increments each cycle. When cnt >= P: square toggles, cnt <= 0, P reloads.
//   Half-period = P+1 cycles.
//  Pluck rising edge (pluck registered, edge = pluck & ~pluck_q): cnt <= 0, square <= 1, amp <= 2^AMP_W-1,
//   decay prescaler <= 0. Uses HP of frets in that same cycle.
//  Pluck low: next cycle cnt, square, amp = 0. Re-pluck while high is impossible; a 1-cycle low gap restarts.
//  Envelope: see CONFIGURATION. amp saturates at 0 (no wrap). active[s] = pluck_q[s] & (amp != 0).
//  Sample s = square ? amp : 0. mix <= sum of all samples, 1 cycle after square/amp update.
//   mix is never overflowing: max NUM_STRINGS*(2^AMP_W-1).
//  speaker: acc (MIX_W+1 b) <= {1'b0,acc[MIX_W-1:0]} + mix. speaker = acc[MIX_W] (registered).
//   Duty = mix/2^MIX_W.
//  Strings are fully independent; simultaneous plucks/mutes on any set of strings in one cycle are legal.
// CONFIGURATION
//  DECAY_EN defined: amp decrements by 1 every DECAY_DIV cycles while pluck high.
//   The prescaler restarts on pluck edge. At amp==0 the note is silent and active drops.
//  DECAY_EN undefined: amp holds 2^AMP_W-1 for as long as pluck is high.
//   The prescaler is not built. active = pluck_q.
// TESTING
//  1 reset low mid-note (string 0 sounding) -> same cycle mix/speaker/active = 0; after release, silence until new pluck.
//  2 frets=0, pluck[0] rise -> square period 2*606723 cycles, mix toggles 0/255.
//    frets=16'h0010, pluck[1] -> half-period 340531 (D3).
//  3 frets=16'h8000, pluck[3] -> HP 101239 (B4, octave 2).
//    frets=16'h0011 -> lowest bit wins, fret 1: string 0 HP 572672.
//  4 string 0 sounding, frets changes 0 -> 16'h0001 mid half-period -> current half keeps 606723 cycles,
//    next halves 572673.
//  5 DECAY_EN, DECAY_DIV=4, AMP_W=8: pluck held -> amp 255 falls 1 per 4 cycles, reaches 0 at 1020 cycles,
//    active drops, stays 0.
//  6 all 4 strings plucked fret 0, squares aligned high -> mix = 1020.
//    speaker duty over 1024 cycles = 1020/1024 +-1.

Source files
------------

// File: rtl/poly_string_synth.sv
// poly_string_synth: per-string square-wave voices with amplitude envelope, registered mixer and
// sigma-delta speaker bitstream. Define DECAY_EN to build the per-string amplitude decay prescaler.
module poly_string_synth #(
   parameter int unsigned              NUM_STRINGS = 4,
   parameter int unsigned              NUM_FRETS   = 16,
   parameter int unsigned              CNT_W       = 20,
   parameter int unsigned              AMP_W       = 8,
   parameter int unsigned              DECAY_DIV   = 390625,
   parameter logic [6*NUM_STRINGS-1:0] NOTE_BASE   = {6'd15, 6'd10, 6'd5, 6'd0},
   localparam int unsigned             MIX_W       = AMP_W + $clog2(NUM_STRINGS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_FRETS-1:0]   frets,
   input  logic [NUM_STRINGS-1:0] pluck,
   output logic [NUM_STRINGS-1:0] active,
   output logic [MIX_W-1:0]       mix,
   output logic                   speaker
);

   if (NUM_STRINGS < 1 || NUM_STRINGS > 8 || DECAY_DIV < 1) begin : g_bad_cfg
      $error("poly_string_synth: NUM_STRINGS must be 1..8 and DECAY_DIV >= 1");
   end

   // Half-period table covers one octave from E2; higher octaves halve by shifting.
   function automatic logic [CNT_W-1:0] half_period(input logic [6:0] note);
      logic [19:0] base;
      case (note % 7'd12)
         7'd0:    base = 20'd606722;
         7'd1:    base = 20'd572672;
         7'd2:    base = 20'd540541;
         7'd3:    base = 20'd510204;
         7'd4:    base = 20'd481556;
         7'd5:    base = 20'd454545;
         7'd6:    base = 20'd429037;
         7'd7:    base = 20'd404957;
         7'd8:    base = 20'd382234;
         7'd9:    base = 20'd360776;
         7'd10:   base = 20'd340530;
         default: base = 20'd321419;
      endcase
      return CNT_W'(base >> (note / 7'd12));
   endfunction

   logic [6:0]             fret;
   logic                   fret_found;
   logic [NUM_STRINGS-1:0] pluck_q;
   logic [AMP_W-1:0]       sample [NUM_STRINGS];
   logic [MIX_W-1:0]       mix_d, mix_q;
   logic [MIX_W:0]         acc_d, acc_q;

   always_comb begin
      fret       = '0;
      fret_found = 1'b0;
      for (int unsigned i = 0; i < NUM_FRETS; i++) begin
         if (frets[i] && !fret_found) begin
            fret       = 7'(i + 1);
            fret_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pluck_q <= '0;
      else        pluck_q <= pluck;
   end

   for (genvar s = 0; s < NUM_STRINGS; s++) begin : g_string
      logic [CNT_W-1:0] cnt_q, per_q, hp;
      logic [AMP_W-1:0] amp_q;
      logic             sq_q, rise, amp_dec;

      assign hp   = half_period(7'(NOTE_BASE[6*s +: 6]) + fret);
      assign rise = pluck[s] & ~pluck_q[s];

`ifdef DECAY_EN
      localparam int unsigned      PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);
      logic [PRE_W-1:0] pre_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset)                                       pre_q <= '0;
         else if (rise || !pluck[s] || pre_q == PRE_LAST)  pre_q <= '0;
         else                                              pre_q <= pre_q + PRE_W'(1);
      end

      assign amp_dec   = pluck[s] & ~rise & (pre_q == PRE_LAST);
      assign active[s] = pluck_q[s] & (amp_q != '0);
`else
      assign amp_dec   = 1'b0;
      assign active[s] = pluck_q[s];
`endif

      // Period register reloads only on pluck and toggles, so fret moves land on a clean edge.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
            per_q <= '0;
            sq_q  <= 1'b0;
            amp_q <= '0;
         end else if (rise) begin
            cnt_q <= '0;
            per_q <= hp;
            sq_q  <= 1'b1;
            amp_q <= '1;
         end else if (pluck[s]) begin
            if (cnt_q >= per_q) begin
               cnt_q <= '0;
               per_q <= hp;
               sq_q  <= ~sq_q;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            if (amp_dec && amp_q != '0) amp_q <= amp_q - AMP_W'(1);
         end else begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
            amp_q <= '0;
         end
      end

      assign sample[s] = sq_q ? amp_q : '0;
   end

   always_comb begin
      mix_d = '0;
      for (int unsigned i = 0; i < NUM_STRINGS; i++) mix_d = mix_d + MIX_W'(sample[i]);
   end

   // First-order sigma-delta: the carry out of the MIX_W-bit accumulator is the speaker bit.
   assign acc_d = {1'b0, acc_q[MIX_W-1:0]} + {1'b0, mix_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mix_q <= '0;
         acc_q <= '0;
      end else begin
         mix_q <= mix_d;
         acc_q <= acc_d;
      end
   end

   assign mix     = mix_q;
   assign speaker = acc_q[MIX_W];

endmodule
